// File: rtl/mem_arbiter.sv
// Two-client (fetch / data) round-robin front end issuing one memory cycle at a time.
// Grant-to-ack >= 4 cycles; clients hold req until their ack pulse, with no other backpressure.
module mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int WORD_W  = 36,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_user,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic              d_user,
  output logic              d_ack,
  output logic [WORD_W-1:0] rd_data,
  output logic              nxm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_user,
  input  logic [WORD_W-1:0] mem_read_data,
  input  logic              mem_ack
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_fetch_q, last_fetch_d;
  logic              gnt_fetch_q, gnt_fetch_d;
  logic              wr_q, wr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              nxm_q, nxm_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_user_q, mem_user_d;
  logic              pick_fetch;

  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    gnt_fetch_d  = gnt_fetch_q;
    wr_d         = wr_q;
    wd_d         = wd_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    rd_data_d    = rd_data_q;
    nxm_d        = nxm_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_user_d   = mem_user_q;
    pick_fetch   = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // With both requesting, the client that lost the previous grant goes first.
          pick_fetch   = if_req && (!d_req || !last_fetch_q);
          gnt_fetch_d  = pick_fetch;
          last_fetch_d = pick_fetch;
          state_d      = ISSUE;
          if (pick_fetch) begin
            mem_addr_d = if_addr;
            mem_user_d = if_user;
            wr_d       = 1'b0;
            mem_read_d = 1'b1;
          end else begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_user_d  = d_user;
            wr_d        = d_write;
            mem_read_d  = !d_write;
            mem_write_d = d_write;
          end
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          if (!wr_q) rd_data_d = mem_read_data;
          nxm_d    = 1'b0;
          if_ack_d = gnt_fetch_q;
          d_ack_d  = !gnt_fetch_q;
          state_d  = DONE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rd_data_d = '0;
          nxm_d     = 1'b1;
          if_ack_d  = gnt_fetch_q;
          d_ack_d   = !gnt_fetch_q;
          state_d   = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_fetch_q <= 1'b0;
      gnt_fetch_q  <= 1'b0;
      wr_q         <= 1'b0;
      wd_q         <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      rd_data_q    <= '0;
      nxm_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_user_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      gnt_fetch_q  <= gnt_fetch_d;
      wr_q         <= wr_d;
      wd_q         <= wd_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      rd_data_q    <= rd_data_d;
      nxm_q        <= nxm_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_user_q   <= mem_user_d;
    end
  end

  assign if_ack         = if_ack_q;
  assign d_ack          = d_ack_q;
  assign rd_data        = rd_data_q;
  assign nxm            = nxm_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_user       = mem_user_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized two-client traffic,
// checked each cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;

  localparam int AW = 18;
  localparam int WW = 36;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0, if_user = 1'b0, if_ack;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0, d_write = 1'b0, d_user = 1'b0, d_ack;
  logic [AW-1:0] d_addr = '0;
  logic [WW-1:0] d_wdata = '0;
  logic [WW-1:0] rd_data, mem_write_data;
  logic          nxm, mem_read, mem_write, mem_user;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_read_data = '0;
  logic          mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_user(if_user), .if_ack(if_ack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_user(d_user), .d_ack(d_ack),
    .rd_data(rd_data), .nxm(nxm),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_user(mem_user),
    .mem_read_data(mem_read_data), .mem_ack(mem_ack)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory image: device side (written from the DUT pins) and reference side
  // (written from what the clients asked for).
  logic [WW-1:0] dev_mem [logic [AW-1:0]];
  logic [WW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [WW-1:0] init_word(input logic [AW-1:0] a);
    return {a, ~a} ^ 36'h05A5A5A5A;
  endfunction
  function automatic bit mapped(input logic [AW-1:0] a);
    return a[AW-1:AW-3] != 3'b111;
  endfunction
  function automatic logic [WW-1:0] dev_rd(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction
  function automatic logic [WW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  int            cyc = 0;
  int            fixed_wait = 0;
  bit            rand_wait = 0;
  int            mem_ack_at = -1;
  logic [WW-1:0] ack_word = '0;

  // Reference model state
  bit            busy = 0, last_fetch = 0;
  int            free_at = 0, ack_cyc = 0;
  bit            cur_fetch = 0, cur_write = 0, cur_user = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [WW-1:0] cur_wdata = '0, exp_rd = '0;

  initial begin
    forever begin
      int  w;
      bit  grant_now, exp_rs, exp_ws, exp_ia, exp_da;
      @(posedge clk); #1;
      cyc++;
      w = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;

      // Memory device: acks mapped addresses 2+w cycles after seeing the strobe.
      mem_ack = (cyc == mem_ack_at);
      mem_read_data = mem_ack ? ack_word : 36'({$urandom(), $urandom()});
      if ((mem_read || mem_write) && mapped(mem_addr)) begin
        if (mem_write) dev_mem[mem_addr] = mem_write_data;
        else           ack_word = dev_rd(mem_addr);
        mem_ack_at = cyc + 2 + w;
      end

      if (reset) begin
        check_eq("rst_if_ack",    64'(if_ack), 64'(0));
        check_eq("rst_d_ack",     64'(d_ack), 64'(0));
        check_eq("rst_mem_read",  64'(mem_read), 64'(0));
        check_eq("rst_mem_write", 64'(mem_write), 64'(0));
        check_eq("rst_mem_addr",  64'(mem_addr), 64'(0));
        check_eq("rst_mem_wdata", 64'(mem_write_data), 64'(0));
        check_eq("rst_mem_user",  64'(mem_user), 64'(0));
        check_eq("rst_rd_data",   64'(rd_data), 64'(0));
        check_eq("rst_nxm",       64'(nxm), 64'(0));
        busy = 0; last_fetch = 0; exp_rd = '0; free_at = cyc + 1;
      end else begin
        grant_now = !busy && cyc >= free_at && (if_req || d_req);
        exp_rs = 0; exp_ws = 0;
        if (grant_now) begin
          if (if_req && d_req) cur_fetch = !last_fetch;
          else                 cur_fetch = if_req;
          last_fetch = cur_fetch;
          if (cur_fetch) begin
            cur_write = 0; cur_addr = if_addr; cur_user = if_user;
          end else begin
            cur_write = d_write; cur_addr = d_addr; cur_user = d_user; cur_wdata = d_wdata;
          end
          exp_ws = cur_write; exp_rs = !cur_write;
          ack_cyc = mapped(cur_addr) ? cyc + 3 + w : cyc + 1 + TO;
          busy = 1;
        end
        check_eq("mem_read",  64'(mem_read), 64'(exp_rs));
        check_eq("mem_write", 64'(mem_write), 64'(exp_ws));
        if (busy) begin
          check_eq("mem_addr", 64'(mem_addr), 64'(cur_addr));
          check_eq("mem_user", 64'(mem_user), 64'(cur_user));
          if (cur_write) check_eq("mem_wdata", 64'(mem_write_data), 64'(cur_wdata));
        end
        exp_ia = busy && cyc == ack_cyc && cur_fetch;
        exp_da = busy && cyc == ack_cyc && !cur_fetch;
        check_eq("if_ack", 64'(if_ack), 64'(exp_ia));
        check_eq("d_ack",  64'(d_ack), 64'(exp_da));
        if (busy && cyc == ack_cyc) begin
          if (mapped(cur_addr)) begin
            check_eq("nxm", 64'(nxm), 64'(0));
            if (cur_write) ref_mem[cur_addr] = cur_wdata;
            else           exp_rd = ref_rd(cur_addr);
          end else begin
            check_eq("nxm", 64'(nxm), 64'(1));
            exp_rd = '0;
          end
          busy = 0;
          free_at = cyc + 2;
        end
        check_eq("rd_data", 64'(rd_data), 64'(exp_rd));
      end
    end
  end

  task automatic fetch_req(input logic [AW-1:0] a, input logic u);
    bit got = 0;
    @(posedge clk); #2;
    if_req = 1'b1; if_addr = a; if_user = u;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #2;
      if (if_ack) got = 1;
    end
    check_eq("if_ack_wait", 64'(got), 64'(1));
    if_req = 1'b0;
  endtask

  task automatic data_req(input logic wr, input logic [AW-1:0] a,
                          input logic [WW-1:0] wd, input logic u);
    bit got = 0;
    @(posedge clk); #2;
    d_req = 1'b1; d_write = wr; d_addr = a; d_wdata = wd; d_user = u;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #2;
      if (d_ack) got = 1;
    end
    check_eq("d_ack_wait", 64'(got), 64'(1));
    d_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [2:0] top;
    top = ($urandom_range(0, 15) == 0) ? 3'b111 : 3'b000;
    return {top, 11'd0, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit got;
    dev_mem[18'o1000] = 36'o123456701234;
    ref_mem[18'o1000] = 36'o123456701234;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Simultaneous requests right after reset: fetch first, then strict alternation.
    fork
      begin fetch_req(18'o3000, 1'b0); fetch_req(18'o3002, 1'b0); fetch_req(18'o3004, 1'b1); end
      begin data_req(1'b0, 18'o3001, '0, 1'b0); data_req(1'b1, 18'o3003, 36'o55, 1'b0);
            data_req(1'b0, 18'o3003, '0, 1'b1); end
    join

    // Zero-wait fetch of a known word; write then read back through the fetch port.
    fetch_req(18'o1000, 1'b0);
    data_req(1'b1, 18'o2000, 36'o777, 1'b1);
    fetch_req(18'o2000, 1'b1);

    // Three memory wait states.
    fixed_wait = 3;
    fetch_req(18'o1000, 1'b0);
    fixed_wait = 0;

    // Unmapped address times out; a late ack afterwards must be ignored.
    data_req(1'b0, 18'o700000, '0, 1'b0);
    mem_ack_at = cyc + 5;
    repeat (8) @(posedge clk);

    // Reset lands on the cycle the pending ack is presented; held req is re-granted.
    fixed_wait = 3;
    @(posedge clk); #2;
    if_req = 1'b1; if_addr = 18'o1000; if_user = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #2;
      if (mem_read) got = 1;
    end
    check_eq("rst_test_grant", 64'(got), 64'(1));
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #2;
      if (if_ack) got = 1;
    end
    check_eq("rst_test_regrant", 64'(got), 64'(1));
    if_req = 1'b0;
    fixed_wait = 0;

    // Randomized traffic from both clients with random memory wait states.
    rand_wait = 1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        fetch_req(rnd_addr(), 1'($urandom_range(0, 1)));
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        data_req(1'($urandom_range(0, 1)), rnd_addr(), 36'({$urandom(), $urandom()}),
                 1'($urandom_range(0, 1)));
      end
    join
    rand_wait = 0;

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
